// File: rtl/score_pkg.sv
// Shared definitions for the score tracker: PS/2 prefix bytes, decoder
// state encoding, default key codes, the score ceiling and saturating
// arithmetic helpers.
package score_pkg;

    localparam logic [7:0]  EXT_PREFIX        = 8'hE0;
    localparam logic [7:0]  BRK_PREFIX        = 8'hF0;

    localparam logic [31:0] MAX_SCORE_DEFAULT = 32'd12;
    localparam logic [7:0]  INC_CODE_DEFAULT  = 8'h29;
    localparam logic [7:0]  CLR_CODE_DEFAULT  = 8'h2D;
    localparam logic [7:0]  DEC_CODE_DEFAULT  = 8'h1C;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_e;

    // Increment that sticks at the ceiling instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                            input logic [31:0] ceiling);
        if (value < ceiling) begin
            return value + 32'd1;
        end else begin
            return ceiling;
        end
    endfunction

    // Decrement that sticks at zero instead of wrapping.
    function automatic logic [31:0] sat_dec(input logic [31:0] value);
        if (value != 32'd0) begin
            return value - 32'd1;
        end else begin
            return 32'd0;
        end
    endfunction

endpackage

// File: rtl/ps2_code_filter.sv
// PS/2 scan-code sequence decoder. Tracks the E0 (extended) and F0 (break)
// prefixes and reports make/break events for non-extended keys only.
// The pulses are decoded from the current state and the incoming byte so
// that the downstream counter can react on the same clock edge that
// accepts the byte.
module ps2_code_filter
    import score_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] key_code,
    input  logic       key_valid,
    output logic       make_pulse,
    output logic       break_pulse,
    output logic [7:0] code
);

    dec_state_e state_q;
    dec_state_e state_d;

    assign code = key_code;

    // Next-state and event decode; the FSM only moves when a byte arrives.
    always_comb begin
        state_d     = state_q;
        make_pulse  = 1'b0;
        break_pulse = 1'b0;
        if (key_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (key_code == EXT_PREFIX) begin
                        state_d = ST_EXT;
                    end else if (key_code == BRK_PREFIX) begin
                        state_d = ST_BRK;
                    end else begin
                        make_pulse = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
                ST_EXT: begin
                    // Extended makes are swallowed here.
                    if (key_code == BRK_PREFIX) begin
                        state_d = ST_EXT_BRK;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    break_pulse = 1'b1;
                    state_d     = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    // Extended breaks are swallowed here.
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Decoder state register with synchronous reset back to IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/score_tracker.sv
// Saturating game-score counter driven by PS/2 key events, with a
// frame-synchronous copy for the VGA display so score changes never tear
// mid-frame. Optional feature macro: SCORE_DEC_EN compiles in a decrement
// key (DEC_CODE) with its own held flag; without it that code is ignored.
module score_tracker
    import score_pkg::*;
#(
    parameter logic [31:0] MAX_SCORE = MAX_SCORE_DEFAULT,
    parameter logic [7:0]  INC_CODE  = INC_CODE_DEFAULT,
    parameter logic [7:0]  CLR_CODE  = CLR_CODE_DEFAULT,
    parameter logic [7:0]  DEC_CODE  = DEC_CODE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  key_code,
    input  logic        key_valid,
    input  logic        frame_end,
    output logic [31:0] score,
    output logic [31:0] score_live,
    output logic        score_full
);

    logic       make_pulse_s;
    logic       break_pulse_s;
    logic [7:0] code_s;

    logic [31:0] live_q;
    logic [31:0] live_d;
    logic [31:0] frame_q;
    logic        inc_held_q;
    logic        inc_held_d;
    logic        clr_held_q;
    logic        clr_held_d;
`ifdef SCORE_DEC_EN
    logic        dec_held_q;
    logic        dec_held_d;
`endif

    ps2_code_filter u_filter (
        .clk         (clk),
        .reset       (reset),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .make_pulse  (make_pulse_s),
        .break_pulse (break_pulse_s),
        .code        (code_s)
    );

    // Key actions: a make acts only when its key is not already held, so
    // typematic repeats are ignored; a break releases the key.
    always_comb begin
        live_d     = live_q;
        inc_held_d = inc_held_q;
        clr_held_d = clr_held_q;
`ifdef SCORE_DEC_EN
        dec_held_d = dec_held_q;
`endif
        if (make_pulse_s) begin
            if (code_s == INC_CODE) begin
                if (!inc_held_q) begin
                    live_d = sat_inc(live_q, MAX_SCORE);
                end else begin
                    live_d = live_q;
                end
                inc_held_d = 1'b1;
            end else if (code_s == CLR_CODE) begin
                if (!clr_held_q) begin
                    live_d = 32'd0;
                end else begin
                    live_d = live_q;
                end
                clr_held_d = 1'b1;
            end
`ifdef SCORE_DEC_EN
            else if (code_s == DEC_CODE) begin
                if (!dec_held_q) begin
                    live_d = sat_dec(live_q);
                end else begin
                    live_d = live_q;
                end
                dec_held_d = 1'b1;
            end
`endif
            else begin
                live_d = live_q;
            end
        end else if (break_pulse_s) begin
            if (code_s == INC_CODE) begin
                inc_held_d = 1'b0;
            end else if (code_s == CLR_CODE) begin
                clr_held_d = 1'b0;
            end
`ifdef SCORE_DEC_EN
            else if (code_s == DEC_CODE) begin
                dec_held_d = 1'b0;
            end
`endif
            else begin
                inc_held_d = inc_held_q;
            end
        end else begin
            live_d = live_q;
        end
    end

    // Live counter and held flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            live_q     <= 32'd0;
            inc_held_q <= 1'b0;
            clr_held_q <= 1'b0;
`ifdef SCORE_DEC_EN
            dec_held_q <= 1'b0;
`endif
        end else begin
            live_q     <= live_d;
            inc_held_q <= inc_held_d;
            clr_held_q <= clr_held_d;
`ifdef SCORE_DEC_EN
            dec_held_q <= dec_held_d;
`endif
        end
    end

    // Frame latch: sample the pre-update live value on each frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_q <= 32'd0;
        end else if (frame_end) begin
            frame_q <= live_q;
        end else begin
            frame_q <= frame_q;
        end
    end

    assign score      = frame_q;
    assign score_live = live_q;
    assign score_full = (live_q == MAX_SCORE);

endmodule
